// File: rtl/cabac_bin_scheduler.sv
// cabac_bin_scheduler
//   Round-robin arbiter that serializes bins from NREQ binarizers onto a single
//   CABAC encode engine. Owns the per-context probability state
//   {valMPS, pStateIdx}, presents the selected context state with each bin and
//   writes back the engine's updated state when the engine reports completion.
//   Optional feature macro: CABAC_SCHED_REINIT_EN adds the ctx_reinit input,
//   which reloads every context from the init table.
module cabac_bin_scheduler #(
  parameter int NREQ = 4,
  parameter int CTXW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef CABAC_SCHED_REINIT_EN
  input  logic                 ctx_reinit,
`endif
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_bin,
  input  logic [NREQ*CTXW-1:0] req_ctx,
  output logic [NREQ-1:0]      req_ready,
  output logic                 eng_valid,
  input  logic                 eng_ready,
  output logic                 eng_bin,
  output logic [5:0]           eng_state,
  output logic                 eng_mps,
  input  logic                 eng_done,
  input  logic [5:0]           eng_state_nxt,
  input  logic                 eng_mps_nxt,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam int NCTX = 2 ** CTXW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  // Context memory, one {valMPS, pStateIdx} word per context.
  logic [6:0] ctx_mem [NCTX];

  logic [2:0]      last_grant;
  logic [2:0]      rr_idx;
  logic            rr_found;
  logic            sel_bin;
  logic [CTXW-1:0] sel_ctx;
  logic [6:0]      sel_rd;
  logic [CTXW-1:0] cap_ctx_p1;
  logic            accept;
  logic            accept_ok;
  logic            wb_en;
  logic            reload_en;

  // Initial probability state for context idx, packed as {valMPS, pStateIdx}.
  function automatic logic [6:0] ctx_init(input int idx);
    logic [6:0] v;
    case (idx)
      0:       v = {1'b0, 6'd32};
      1:       v = {1'b0, 6'd17};
      2:       v = {1'b0, 6'd10};
      3:       v = {1'b0, 6'd5};
      4:       v = {1'b0, 6'd2};
      5:       v = {1'b1, 6'd1};
      6:       v = {1'b1, 6'd5};
      7:       v = {1'b1, 6'd11};
      8:       v = {1'b1, 6'd19};
      default: v = 7'd0;
    endcase
    return v;
  endfunction

`ifdef CABAC_SCHED_REINIT_EN
  logic reinit_pend;

  // Accepts wait while a reload is requested now or still pending.
  assign accept_ok = !ctx_reinit && !reinit_pend;
  // Reload immediately in IDLE, or at the engine-done edge of the bin in flight.
  assign reload_en = ((state == S_IDLE) && ctx_reinit) ||
                     ((state == S_WAIT) && eng_done && (reinit_pend || ctx_reinit));

  // Remember a reload request that arrives while a bin is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reinit_pend <= 1'b0;
    end else if ((state == S_WAIT) && eng_done) begin
      reinit_pend <= 1'b0;
    end else if ((state != S_IDLE) && ctx_reinit) begin
      reinit_pend <= 1'b1;
    end
  end
`else
  assign accept_ok = 1'b1;
  assign reload_en = 1'b0;
`endif

  assign wb_en = (state == S_WAIT) && eng_done;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int c;
    c        = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last_grant) + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if ((i == c) && req_valid[i] && !rr_found) begin
          rr_found = 1'b1;
          rr_idx   = 3'(i);
        end
      end
    end
  end

  // Select the winner's bin and context, and look up its current state.
  always_comb begin
    sel_bin = 1'b0;
    sel_ctx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_idx == 3'(i)) begin
        sel_bin = req_bin[i];
        sel_ctx = req_ctx[i*CTXW +: CTXW];
      end
    end
    sel_rd = ctx_mem[sel_ctx];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    eng_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rr_found && accept_ok) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
          for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (rr_idx == 3'(i));
          end
        end
      end
      S_ISSUE: begin
        eng_valid = 1'b1;
        busy      = 1'b1;
        if (eng_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (eng_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- accept stage: capture bin, context and its state for the engine ----
  // Capture the accepted bin; outputs then hold steady through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_bin    <= 1'b0;
      eng_state  <= 6'd0;
      eng_mps    <= 1'b0;
      grant_id   <= 3'd0;
      cap_ctx_p1 <= '0;
      last_grant <= 3'(NREQ - 1);
    end else if (accept) begin
      eng_bin    <= sel_bin;
      eng_state  <= sel_rd[5:0];
      eng_mps    <= sel_rd[6];
      grant_id   <= rr_idx;
      cap_ctx_p1 <= sel_ctx;
      last_grant <= rr_idx;
    end
  end

  // ---- write-back stage: update context memory on engine completion ----
  // Reload overrides a same-edge write-back so the init table wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCTX; i++) begin
        ctx_mem[i] <= ctx_init(i);
      end
    end else if (reload_en) begin
      for (int i = 0; i < NCTX; i++) begin
        ctx_mem[i] <= ctx_init(i);
      end
    end else if (wb_en) begin
      ctx_mem[cap_ctx_p1] <= {eng_mps_nxt, eng_state_nxt};
    end
  end

endmodule
